data_memory_stage_skid: RTL and testbench

Parametrised valid/ready pipeline register between execute and data-memory access. It carries the destination register address, ALU result, load/store encodings, store data, write-back select and write enable. It adds handshake-based stall, synchronous flush (bubble insertion), an optional 2-entry skid buffer that registers READY_OUT, control gating on bubbles, and a saturating stall-cycle counter.

---
 rtl/data_memory_stage_skid_if.sv | 52 +++++
 rtl/data_memory_stage_skid.sv | 171 +++++++++++++++++
 tb/tb_data_memory_stage_skid.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_stage_skid_if.sv
// Handshake and payload bundle between execute and the data-memory pipeline stage.
// The slave modport is the stage's view. The master modport is the view of the
// environment that feeds the stage and drains it.
interface data_memory_stage_skid_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LOAD_WIDTH     = 3,
   parameter int STORE_WIDTH    = 2,
   parameter int COUNTER_WIDTH  = 16
);
   // upstream side
   logic                      FLUSH;
   logic                      VALID_IN;
   logic                      READY_OUT;
   logic [REG_ADDR_WIDTH-1:0] RD_ADDRESS_IN;
   logic [DATA_WIDTH-1:0]     ALU_OUT_IN;
   logic [LOAD_WIDTH-1:0]     DATA_CACHE_LOAD_IN;
   logic [STORE_WIDTH-1:0]    DATA_CACHE_STORE_IN;
   logic [DATA_WIDTH-1:0]     DATA_CACHE_STORE_DATA_IN;
   logic                      WRITE_BACK_MUX_SELECT_IN;
   logic                      RD_WRITE_ENABLE_IN;
   // downstream side
   logic                      VALID_OUT;
   logic                      READY_IN;
   logic [REG_ADDR_WIDTH-1:0] RD_ADDRESS_OUT;
   logic [DATA_WIDTH-1:0]     ALU_OUT_OUT;
   logic [LOAD_WIDTH-1:0]     DATA_CACHE_LOAD_OUT;
   logic [STORE_WIDTH-1:0]    DATA_CACHE_STORE_OUT;
   logic [DATA_WIDTH-1:0]     DATA_CACHE_STORE_DATA_OUT;
   logic                      WRITE_BACK_MUX_SELECT_OUT;
   logic                      RD_WRITE_ENABLE_OUT;
   // status
   logic [COUNTER_WIDTH-1:0]  STALL_CYCLES;

   modport slave (
      input  FLUSH, VALID_IN, RD_ADDRESS_IN, ALU_OUT_IN, DATA_CACHE_LOAD_IN,
             DATA_CACHE_STORE_IN, DATA_CACHE_STORE_DATA_IN, WRITE_BACK_MUX_SELECT_IN,
             RD_WRITE_ENABLE_IN, READY_IN,
      output READY_OUT, VALID_OUT, RD_ADDRESS_OUT, ALU_OUT_OUT, DATA_CACHE_LOAD_OUT,
             DATA_CACHE_STORE_OUT, DATA_CACHE_STORE_DATA_OUT, WRITE_BACK_MUX_SELECT_OUT,
             RD_WRITE_ENABLE_OUT, STALL_CYCLES
   );

   modport master (
      output FLUSH, VALID_IN, RD_ADDRESS_IN, ALU_OUT_IN, DATA_CACHE_LOAD_IN,
             DATA_CACHE_STORE_IN, DATA_CACHE_STORE_DATA_IN, WRITE_BACK_MUX_SELECT_IN,
             RD_WRITE_ENABLE_IN, READY_IN,
      input  READY_OUT, VALID_OUT, RD_ADDRESS_OUT, ALU_OUT_OUT, DATA_CACHE_LOAD_OUT,
             DATA_CACHE_STORE_OUT, DATA_CACHE_STORE_DATA_OUT, WRITE_BACK_MUX_SELECT_OUT,
             RD_WRITE_ENABLE_OUT, STALL_CYCLES
   );
endinterface

// File: rtl/data_memory_stage_skid.sv
// Execute -> data-memory pipeline register with valid/ready handshake.
// It supports a synchronous flush and an optional two-entry skid buffer, which keeps
// READY_OUT off the downstream combinational path. It also keeps a saturating count
// of backpressured cycles.
// The control fields of the main register (write enable, load type, store type) are
// stored already gated. A bubble therefore drives zeros on them directly from flops.
module data_memory_stage_skid #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LOAD_WIDTH     = 3,
   parameter int STORE_WIDTH    = 2,
   parameter int SKID_ENABLE    = 1,
   parameter int COUNTER_WIDTH  = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   data_memory_stage_skid_if.slave  stage_if
);

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] rd_addr;
      logic [DATA_WIDTH-1:0]     alu_out;
      logic [LOAD_WIDTH-1:0]     load_type;
      logic [STORE_WIDTH-1:0]    store_type;
      logic [DATA_WIDTH-1:0]     store_data;
      logic                      wb_sel;
      logic                      rd_we;
   } payload_t;

   localparam int                     PAYLOAD_W = $bits(payload_t);
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

   payload_t                 payload_in;
   payload_t                 payload_m_q;
   payload_t                 payload_m_d;
   logic                     valid_m_q;
   logic                     valid_m_d;
   logic                     ready_out;
   logic                     accept;
   logic                     issue;
   logic [COUNTER_WIDTH-1:0] stall_cnt_q;
   logic [COUNTER_WIDTH-1:0] stall_cnt_d;

   assign payload_in.rd_addr    = stage_if.RD_ADDRESS_IN;
   assign payload_in.alu_out    = stage_if.ALU_OUT_IN;
   assign payload_in.load_type  = stage_if.DATA_CACHE_LOAD_IN;
   assign payload_in.store_type = stage_if.DATA_CACHE_STORE_IN;
   assign payload_in.store_data = stage_if.DATA_CACHE_STORE_DATA_IN;
   assign payload_in.wb_sel     = stage_if.WRITE_BACK_MUX_SELECT_IN;
   assign payload_in.rd_we      = stage_if.RD_WRITE_ENABLE_IN;

   assign accept = stage_if.VALID_IN & ready_out;
   assign issue  = valid_m_q & stage_if.READY_IN;

   if (SKID_ENABLE != 0) begin : g_skid
      payload_t payload_s_q;
      payload_t payload_s_d;
      logic     valid_s_q;
      logic     valid_s_d;
      logic     ready_out_q;
      logic     ready_out_d;

      // Next state of main and skid entries: refill M from S first, park a new entry in S when M is stuck
      always_comb begin
         payload_m_d = payload_m_q;
         valid_m_d   = valid_m_q;
         payload_s_d = payload_s_q;
         valid_s_d   = valid_s_q;
         if (stage_if.FLUSH) begin
            valid_m_d = 1'b0;
            valid_s_d = 1'b0;
         end else if (issue || !valid_m_q) begin
            if (valid_s_q) begin
               payload_m_d = payload_s_q;
               valid_m_d   = 1'b1;
            end else begin
               payload_m_d = payload_in;
               valid_m_d   = accept;
            end
            valid_s_d = 1'b0;
         end else if (accept) begin
            payload_s_d = payload_in;
            valid_s_d   = 1'b1;
         end else begin
            valid_s_d = valid_s_q;
         end
         if (!valid_m_d) begin
            payload_m_d.rd_we      = 1'b0;
            payload_m_d.load_type  = {LOAD_WIDTH{1'b0}};
            payload_m_d.store_type = {STORE_WIDTH{1'b0}};
         end else begin
            payload_m_d.rd_we = payload_m_d.rd_we;
         end
         ready_out_d = !valid_s_d;
      end

      // Skid entry and registered ready
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            payload_s_q <= payload_t'({PAYLOAD_W{1'b0}});
            valid_s_q   <= 1'b0;
            ready_out_q <= 1'b1;
         end else begin
            payload_s_q <= payload_s_d;
            valid_s_q   <= valid_s_d;
            ready_out_q <= ready_out_d;
         end
      end

      assign ready_out = ready_out_q;
   end else begin : g_single
      assign ready_out = stage_if.READY_IN | ~valid_m_q;

      // Next state of the single main entry: load whenever the slot is free or draining
      always_comb begin
         payload_m_d = payload_m_q;
         valid_m_d   = valid_m_q;
         if (stage_if.FLUSH) begin
            valid_m_d = 1'b0;
         end else if (ready_out) begin
            payload_m_d = payload_in;
            valid_m_d   = accept;
         end else begin
            valid_m_d = valid_m_q;
         end
         if (!valid_m_d) begin
            payload_m_d.rd_we      = 1'b0;
            payload_m_d.load_type  = {LOAD_WIDTH{1'b0}};
            payload_m_d.store_type = {STORE_WIDTH{1'b0}};
         end else begin
            payload_m_d.rd_we = payload_m_d.rd_we;
         end
      end
   end

   // Saturating backpressure counter; a flush cycle never counts
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!stage_if.FLUSH && valid_m_q && !stage_if.READY_IN && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Main entry and counter registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         payload_m_q <= payload_t'({PAYLOAD_W{1'b0}});
         valid_m_q   <= 1'b0;
         stall_cnt_q <= {COUNTER_WIDTH{1'b0}};
      end else begin
         payload_m_q <= payload_m_d;
         valid_m_q   <= valid_m_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stage_if.READY_OUT                 = ready_out;
   assign stage_if.VALID_OUT                 = valid_m_q;
   assign stage_if.RD_ADDRESS_OUT            = payload_m_q.rd_addr;
   assign stage_if.ALU_OUT_OUT               = payload_m_q.alu_out;
   assign stage_if.DATA_CACHE_LOAD_OUT       = payload_m_q.load_type;
   assign stage_if.DATA_CACHE_STORE_OUT      = payload_m_q.store_type;
   assign stage_if.DATA_CACHE_STORE_DATA_OUT = payload_m_q.store_data;
   assign stage_if.WRITE_BACK_MUX_SELECT_OUT = payload_m_q.wb_sel;
   assign stage_if.RD_WRITE_ENABLE_OUT       = payload_m_q.rd_we;
   assign stage_if.STALL_CYCLES              = stall_cnt_q;

endmodule

// File: tb/tb_data_memory_stage_skid.sv
// Randomized and directed bench for data_memory_stage_skid.
// Three instances share one stimulus:
//   0: skid mode, 16-bit counter
//   1: skid mode, 4-bit counter
//   2: single-register mode, 16-bit counter
// The reference model for each instance is a FIFO with capacity 2 or 1.
module tb_data_memory_stage_skid;
   localparam int PW = 76;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, valid_in, ready_in;
   logic [4:0]  rd;
   logic [31:0] alu, sdata;
   logic [2:0]  ld;
   logic [1:0]  st;
   logic        wb, we;

   logic          o_valid [3];
   logic          o_ready [3];
   logic [PW-1:0] o_pl    [3];
   logic [15:0]   o_stall [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int SK = (g == 2) ? 0 : 1;
      localparam int CW = (g == 1) ? 4 : 16;
      data_memory_stage_skid_if #(.COUNTER_WIDTH(CW)) u_if ();
      assign u_if.FLUSH                    = flush;
      assign u_if.VALID_IN                 = valid_in;
      assign u_if.READY_IN                 = ready_in;
      assign u_if.RD_ADDRESS_IN            = rd;
      assign u_if.ALU_OUT_IN               = alu;
      assign u_if.DATA_CACHE_LOAD_IN       = ld;
      assign u_if.DATA_CACHE_STORE_IN      = st;
      assign u_if.DATA_CACHE_STORE_DATA_IN = sdata;
      assign u_if.WRITE_BACK_MUX_SELECT_IN = wb;
      assign u_if.RD_WRITE_ENABLE_IN       = we;
      data_memory_stage_skid #(.SKID_ENABLE(SK), .COUNTER_WIDTH(CW)) u_dut (
         .CLK(clk), .RST(rst), .stage_if(u_if));
      assign o_valid[g] = u_if.VALID_OUT;
      assign o_ready[g] = u_if.READY_OUT;
      assign o_pl[g]    = {u_if.RD_ADDRESS_OUT, u_if.ALU_OUT_OUT, u_if.DATA_CACHE_LOAD_OUT,
                           u_if.DATA_CACHE_STORE_OUT, u_if.DATA_CACHE_STORE_DATA_OUT,
                           u_if.WRITE_BACK_MUX_SELECT_OUT, u_if.RD_WRITE_ENABLE_OUT};
      assign o_stall[g] = 16'(u_if.STALL_CYCLES);
   end

   // reference model: per-instance FIFO contents, fill level, stall count
   logic [PW-1:0] mq [3][2];
   int mcnt   [3];
   int mstall [3];
   int cap    [3] = '{2, 2, 1};
   int cmax   [3] = '{65535, 15, 65535};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_ready(input int i);
      if (cap[i] == 2) return (mcnt[i] < 2);
      return ready_in || (mcnt[i] == 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mcnt[i]   = 0;
         mstall[i] = 0;
      end
   endtask

   task automatic set_in(input logic v, input logic r, input logic f, input logic [31:0] a);
      valid_in = v;
      ready_in = r;
      flush    = f;
      alu      = a;
      rd       = 5'($urandom);
      ld       = 3'($urandom);
      st       = 2'($urandom);
      sdata    = $urandom;
      wb       = 1'($urandom);
      we       = 1'($urandom);
   endtask

   // check the settled outputs, advance the model across the next edge, return at edge+1
   task automatic step();
      logic [PW-1:0] inp;
      logic acc, iss;
      #2;
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("ready[%0d]", i), PW'(o_ready[i]), PW'(exp_ready(i)));
         check_val($sformatf("valid[%0d]", i), PW'(o_valid[i]), PW'(mcnt[i] > 0));
         check_val($sformatf("stall[%0d]", i), PW'(o_stall[i]), PW'(mstall[i]));
         if (mcnt[i] > 0)
            check_val($sformatf("payload[%0d]", i), o_pl[i], mq[i][0]);
         else
            check_val($sformatf("gate[%0d]", i), PW'({o_pl[i][38:34], o_pl[i][0]}), PW'(0));
      end
      inp = {rd, alu, ld, st, sdata, wb, we};
      for (int i = 0; i < 3; i++) begin
         acc = valid_in && exp_ready(i);
         iss = (mcnt[i] > 0) && ready_in;
         if (flush) begin
            mcnt[i] = 0;
         end else begin
            if ((mcnt[i] > 0) && !ready_in && (mstall[i] < cmax[i])) mstall[i]++;
            if (iss) begin
               mq[i][0] = mq[i][1];
               mcnt[i]--;
            end
            if (acc) begin
               mq[i][mcnt[i]] = inp;
               mcnt[i]++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic random_phase(input int n);
      for (int k = 0; k < n; k++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0, $urandom);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      model_reset();
      #3;
      for (int i = 0; i < 3; i++) begin
         check_val("rst_ready", PW'(o_ready[i]), PW'(1));
         check_val("rst_valid", PW'(o_valid[i]), PW'(0));
         check_val("rst_stall", PW'(o_stall[i]), PW'(0));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // streaming
      for (int k = 1; k <= 8; k++) begin
         set_in(1'b1, 1'b1, 1'b0, 32'(k));
         step();
      end
      set_in(1'b0, 1'b1, 1'b0, 32'h0);
      step();

      // backpressure: A, B, C offered while downstream is stalled
      set_in(1'b1, 1'b0, 1'b0, 32'h10); step();
      set_in(1'b1, 1'b0, 1'b0, 32'h20); step();
      set_in(1'b1, 1'b0, 1'b0, 32'h30); step();
      set_in(1'b1, 1'b0, 1'b0, 32'h30); step();
      set_in(1'b1, 1'b1, 1'b0, 32'h30); step();
      set_in(1'b0, 1'b1, 1'b0, 32'h0);  step();
      step();
      step();

      // flush with both entries full and live control fields
      set_in(1'b1, 1'b0, 1'b0, 32'h40); we = 1'b1; st = 2'd2; step();
      set_in(1'b1, 1'b0, 1'b0, 32'h50); we = 1'b1; st = 2'd2; step();
      set_in(1'b1, 1'b0, 1'b1, 32'h60); we = 1'b1; st = 2'd2; step();
      set_in(1'b0, 1'b1, 1'b0, 32'h0);  step();
      step();

      // saturation: hold a valid entry against backpressure for 20 cycles
      set_in(1'b1, 1'b0, 1'b0, 32'h70); step();
      for (int k = 0; k < 20; k++) begin
         set_in(1'b0, 1'b0, 1'b0, 32'h0);
         step();
      end
      #2;
      check_val("sat15", PW'(o_stall[1]), PW'(15));
      @(posedge clk);
      #1;
      check_val("sat15_hold", PW'(o_stall[1]), PW'(15));
      for (int i = 0; i < 3; i++)
         if (mcnt[i] > 0 && mstall[i] < cmax[i]) mstall[i]++;

      // ready_in toggling 1,0,1 with continuous valid
      for (int k = 0; k < 12; k++) begin
         set_in(1'b1, (k % 3) != 1, 1'b0, 32'h100 + 32'(k));
         step();
      end

      random_phase(250);

      // asynchronous reset mid-stream with both entries full
      set_in(1'b1, 1'b0, 1'b0, 32'h200); step();
      set_in(1'b1, 1'b0, 1'b0, 32'h201); step();
      set_in(1'b1, 1'b0, 1'b0, 32'h202);
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_val("arst_valid", PW'(o_valid[i]), PW'(0));
         check_val("arst_ready", PW'(o_ready[i]), PW'(1));
         check_val("arst_stall", PW'(o_stall[i]), PW'(0));
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      random_phase(250);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
